// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and parity-mode constants for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: line synchroniser, falling-edge detect, bit timer and 3-sample majority vote
module uart_bit_sampler #(
    parameter int DIV = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic serial,
    input  logic run,
    output logic fall,
    output logic vote,
    output logic vote_valid,
    output logic bit_end
);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    logic [2:0]    sync;
    logic [CW-1:0] cnt;
    logic [1:0]    smp;
    logic          line;

    assign line       = sync[1];
    assign fall       = sync[2] & ~sync[1];
    assign vote       = (smp[0] & smp[1]) | (smp[0] & line) | (smp[1] & line);
    assign vote_valid = run && cnt == CW'(HALF + 1);
    assign bit_end    = run && cnt == CW'(DIV - 1);

    // two synchroniser flops plus one history flop for edge detection, all idle-high after reset
    always_ff @(posedge clk)
        sync <= !rst_n ? 3'b111 : {sync[1:0], serial};

    // bit timer runs only while a frame is in progress and restarts from zero whenever idle
    always_ff @(posedge clk)
        cnt <= (!rst_n || !run || cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;

    // hold the first two mid-bit samples; the third is the live synchronised line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp <= '0;
        end else begin
            if (cnt == CW'(HALF - 1)) smp[0] <= line;
            if (cnt == CW'(HALF))     smp[1] <= line;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with majority-vote sampling and a one-word output register
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ  = 50000000,
    parameter int BAUD_RATE   = 4000000,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 uart_clock,
    input  logic                 uart_reset,
    input  logic                 uart_d_in,
    output logic [DATA_BITS-1:0] uart_d_out,
    output logic                 uart_valid,
    input  logic                 uart_ready,
    output logic                 uart_parity_err,
    output logic                 uart_frame_err,
    output logic                 uart_overrun
);
    localparam int DIV = CLOCK_FREQ / BAUD_RATE;

    if (DIV < 4) begin : g_div_check
        $error("uart_rx_cfg: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    state_t               state, next;
    logic                 fall, vote, vote_valid, bit_end, done;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, ferr_acc, par_x, perr_now;

    assign par_x    = ^{shreg, par_bit};
    assign perr_now = (PARITY_MODE == PAR_EVEN) ? par_x : (PARITY_MODE == PAR_ODD) ? ~par_x : 1'b0;

    uart_bit_sampler #(.DIV(DIV)) u_sampler (
        .clk        (uart_clock),
        .rst_n      (uart_reset),
        .serial     (uart_d_in),
        .run        (state != IDLE),
        .fall       (fall),
        .vote       (vote),
        .vote_valid (vote_valid),
        .bit_end    (bit_end)
    );

    // frame sequencing; completion fires at the vote of the last stop bit, not at its end
    always_comb begin
        next = state;
        done = 1'b0;
        case (state)
            IDLE:    next = fall ? START : IDLE;
            START:   next = (vote_valid && vote) ? IDLE : bit_end ? DATA : START;
            DATA:    next = (bit_end && bit_idx == 4'(DATA_BITS - 1))
                            ? ((PARITY_MODE != PAR_NONE) ? PARITY : STOP) : DATA;
            PARITY:  next = bit_end ? STOP : PARITY;
            STOP: begin
                done = vote_valid && bit_idx == 4'(STOP_BITS - 1);
                next = done ? IDLE : STOP;
            end
            default: next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge uart_clock)
        state <= !uart_reset ? IDLE : next;

    // bit index, LSB-first data shift, parity capture and stop-bit error accumulation
    always_ff @(posedge uart_clock) begin
        if (!uart_reset) begin
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            bit_idx  <= (next != state) ? '0
                      : (bit_end && (state == DATA || state == STOP)) ? bit_idx + 4'd1 : bit_idx;
            shreg    <= (state == DATA && vote_valid) ? {vote, shreg[DATA_BITS-1:1]} : shreg;
            par_bit  <= (state == PARITY && vote_valid) ? vote : par_bit;
            ferr_acc <= (state == START) ? 1'b0
                      : (state == STOP && vote_valid && !vote) ? 1'b1 : ferr_acc;
        end
    end

    // output register: load when empty or being drained, otherwise drop the word and flag overrun
    always_ff @(posedge uart_clock) begin
        if (!uart_reset) begin
            uart_d_out      <= '0;
            uart_valid      <= 1'b0;
            uart_parity_err <= 1'b0;
            uart_frame_err  <= 1'b0;
            uart_overrun    <= 1'b0;
        end else begin
            uart_overrun <= done && uart_valid && !uart_ready;
            if (done && (!uart_valid || uart_ready)) begin
                uart_d_out      <= shreg;
                uart_parity_err <= perr_now;
                uart_frame_err  <= ferr_acc | ~vote;
                uart_valid      <= 1'b1;
            end else if (uart_ready) begin
                uart_valid <= 1'b0;
            end
        end
    end

endmodule
